// File: rtl/sample_replay_ctrl.sv
// Sample FIFO sequencer: fills a batch from upstream, replays it downstream i_passes times
// via FIFO mark/read-reset, then flushes. Optional stall counter under SAMPLE_REPLAY_STATS_EN.
module sample_replay_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1000,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PASS_W = 8,
  parameter int unsigned SETTLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic [PASS_W-1:0] i_passes,
  input  logic              i_in_vld,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_rdy,
  output logic              o_out_vld,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_last,
  input  logic              i_out_rdy,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fifo_flush,
  output logic              o_fifo_mark,
  output logic              o_fifo_read_rst,
  output logic              o_fifo_push,
  output logic              o_fifo_pop,
  output logic [DATA_W-1:0] o_fifo_rear,
  input  logic              i_fifo_full,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_front,
  output logic [15:0]       o_stall_cycles
);

  typedef enum logic [2:0] {StIdle, StFill, StMark, StDrain, StRewind, StFlush} state_e;

  localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);
  localparam logic [7:0]       SettleC = 8'(SETTLE);

  state_e              state_q;
  logic [CNT_W-1:0]    len_q, wcnt_q, rcnt_q, ocnt_q;
  logic [PASS_W-1:0]   passes_q, pcnt_q;
  logic [7:0]          scnt_q;
  logic [DATA_W-1:0]   buf0_q, buf1_q;
  logic [1:0]          occ_q, occ_after;
  logic                pop_q;
  logic                start_ok, in_hs, out_hs, last_hs, credit;
  logic [2:0]          used;

  assign start_ok = i_start & (state_q == StIdle);

  assign o_in_rdy    = (state_q == StFill) & ~i_fifo_full;
  assign in_hs       = o_in_rdy & i_in_vld;
  assign o_fifo_push = in_hs;
  assign o_fifo_rear = in_hs ? i_in_data : '0;

  assign o_out_vld  = (occ_q != 2'd0);
  assign o_out_data = o_out_vld ? buf0_q : '0;
  assign o_out_last = o_out_vld & (ocnt_q == len_q - 1'b1);
  assign out_hs     = o_out_vld & i_out_rdy;
  assign last_hs    = out_hs & o_out_last;

  // A slot freed by this cycle's downstream accept can be reused at once, sustaining 1/cycle.
  assign used       = 3'(occ_q) + 3'(pop_q);
  assign credit     = used < (3'd2 + 3'(out_hs));
  assign o_fifo_pop = (state_q == StDrain) & credit & (rcnt_q < len_q) & ~i_fifo_empty;
  assign occ_after  = occ_q - 2'(out_hs);

  assign o_fifo_mark     = (state_q == StMark) & (scnt_q == SettleC - 8'd1);
  assign o_fifo_read_rst = (state_q == StRewind) & (scnt_q == 8'd0);
  assign o_fifo_flush    = (state_q == StFlush);
  assign o_done          = (state_q == StFlush);
  assign o_busy          = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      ocnt_q   <= '0;
      passes_q <= '0;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      occ_q    <= '0;
      pop_q    <= 1'b0;
    end else begin
      pop_q <= o_fifo_pop;
      // Two-entry output buffer; buf0_q is always the head.
      if (out_hs) buf0_q <= buf1_q;
      if (pop_q) begin
        if (occ_after == 2'd0) buf0_q <= i_fifo_front;
        else                   buf1_q <= i_fifo_front;
      end
      occ_q <= occ_after + 2'(pop_q);

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            len_q    <= (i_len > DepthC) ? DepthC : i_len;
            passes_q <= i_passes;
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            state_q  <= ((i_len == '0) || (i_passes == '0)) ? StFlush : StFill;
          end
        end
        StFill: begin
          if (in_hs) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q + 1'b1 == len_q) begin
              state_q <= StMark;
              scnt_q  <= '0;
            end
          end
        end
        StMark: begin
          if (scnt_q == SettleC - 8'd1) begin
            state_q <= StDrain;
            rcnt_q  <= '0;
            ocnt_q  <= '0;
            pcnt_q  <= '0;
          end else begin
            scnt_q <= scnt_q + 8'd1;
          end
        end
        StDrain: begin
          if (o_fifo_pop) rcnt_q <= rcnt_q + 1'b1;
          if (out_hs)     ocnt_q <= ocnt_q + 1'b1;
          if (last_hs) begin
            pcnt_q  <= pcnt_q + 1'b1;
            scnt_q  <= '0;
            state_q <= (pcnt_q + 1'b1 == passes_q) ? StFlush : StRewind;
          end
        end
        StRewind: begin
          // One read-reset cycle followed by SETTLE quiet cycles.
          if (scnt_q == SettleC) begin
            state_q <= StDrain;
            rcnt_q  <= '0;
            ocnt_q  <= '0;
          end else begin
            scnt_q <= scnt_q + 8'd1;
          end
        end
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SAMPLE_REPLAY_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == StDrain) && o_out_vld && !i_out_rdy && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cycles = stall_q;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sample_replay_ctrl.sv
// Bench for sample_replay_ctrl: behavioural FIFO with mark/read-reset, expected-sample queue
// filled at stimulus time and drained by an output monitor.
module tb_sample_replay_ctrl;

  logic        clk, rst_n;
  logic        i_start;
  logic [15:0] i_len;
  logic [7:0]  i_passes;
  logic        i_in_vld;
  logic [15:0] i_in_data;
  logic        o_in_rdy;
  logic        o_out_vld;
  logic [15:0] o_out_data;
  logic        o_out_last;
  logic        i_out_rdy;
  logic        o_busy, o_done;
  logic        fifo_flush, fifo_mark, fifo_read_rst, fifo_push, fifo_pop;
  logic [15:0] fifo_rear;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_front;
  logic [15:0] o_stall_cycles;

  sample_replay_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_len           (i_len),
    .i_passes        (i_passes),
    .i_in_vld        (i_in_vld),
    .i_in_data       (i_in_data),
    .o_in_rdy        (o_in_rdy),
    .o_out_vld       (o_out_vld),
    .o_out_data      (o_out_data),
    .o_out_last      (o_out_last),
    .i_out_rdy       (i_out_rdy),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_fifo_flush    (fifo_flush),
    .o_fifo_mark     (fifo_mark),
    .o_fifo_read_rst (fifo_read_rst),
    .o_fifo_push     (fifo_push),
    .o_fifo_pop      (fifo_pop),
    .o_fifo_rear     (fifo_rear),
    .i_fifo_full     (fifo_full),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_front    (fifo_front),
    .o_stall_cycles  (o_stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always high, 1 = toggle each cycle, 2 = held low.
  int rdy_mode = 0;
  initial begin
    i_out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_out_rdy = 1'b1;
        1:       i_out_rdy = ~i_out_rdy;
        default: i_out_rdy = 1'b0;
      endcase
    end
  end

  // Behavioural FIFO: front is registered one cycle after pop.
  logic [15:0] mem [0:1023];
  int wptr = 0, rptr = 0, mptr = 0;
  int n_push = 0, n_pop = 0, n_mark = 0, n_rrst = 0, n_flush = 0;
  assign fifo_empty = (rptr == wptr);
  assign fifo_full  = ((wptr - rptr) >= 1000);

  always @(posedge clk) begin
    if (!rst_n) begin
      wptr <= 0; rptr <= 0; mptr <= 0; fifo_front <= '0;
    end else if (fifo_flush) begin
      wptr <= 0; rptr <= 0; mptr <= 0;
    end else begin
      if (fifo_push) begin
        mem[wptr % 1024] <= fifo_rear;
        wptr <= wptr + 1;
      end
      if (fifo_mark) mptr <= rptr;
      if (fifo_read_rst) rptr <= mptr;
      else if (fifo_pop) begin
        fifo_front <= mem[rptr % 1024];
        rptr <= rptr + 1;
      end
    end
    if (fifo_push)     n_push  <= n_push + 1;
    if (fifo_pop)      n_pop   <= n_pop + 1;
    if (fifo_mark)     n_mark  <= n_mark + 1;
    if (fifo_read_rst) n_rrst  <= n_rrst + 1;
    if (fifo_flush)    n_flush <= n_flush + 1;
  end

  // Scoreboard: {last, data}
  logic [16:0] exp_q[$];
  logic [16:0] e;
  int n_out = 0, n_last = 0, n_stall = 0, last_hs_cyc = 0;
  int first_pop = -1, first_vld = -1;
  logic stall_prev = 1'b0, stab_en = 1'b1;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (o_out_vld && i_out_rdy) begin
      check("out_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", 64'(o_out_data), 64'(e[15:0]));
        check("out_last", 64'(o_out_last), 64'(e[16]));
      end
      n_out++;
      if (o_out_last) begin
        n_last++;
        last_hs_cyc = cyc;
      end
    end
    if (stab_en && stall_prev) begin
      check("stall_vld_held", 64'(o_out_vld), 64'(1));
      check("stall_data_held", 64'(o_out_data), 64'(prev_data));
    end
    stall_prev = o_out_vld && !i_out_rdy;
    prev_data  = o_out_data;
    if (stall_prev) n_stall++;
    if (fifo_pop) begin
      check("pop_not_empty", 64'(fifo_empty), 64'(0));
      if (first_pop < 0) first_pop = cyc;
    end
    if (o_out_vld && first_vld < 0) first_vld = cyc;
    if (o_done) check("done_with_flush", 64'(fifo_flush), 64'(1));
  end

  logic [63:0] all_out;
  assign all_out = {6'd0, o_in_rdy, o_out_vld, o_out_data, o_out_last, o_busy, o_done,
                    fifo_flush, fifo_mark, fifo_read_rst, fifo_push, fifo_pop, fifo_rear,
                    o_stall_cycles};

  int b_push, b_pop, b_mark, b_rrst, b_flush, b_out, b_last, b_stall, done_cyc;

  task automatic snap();
    b_push = n_push; b_pop = n_pop; b_mark = n_mark; b_rrst = n_rrst; b_flush = n_flush;
    b_out = n_out; b_last = n_last; b_stall = n_stall;
    first_pop = -1; first_vld = -1;
  endtask

  task automatic expect_job(input logic [15:0] base, input int len, input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), 16'(base + 16'(i))});
  endtask

  task automatic start_job(input int len, input int passes);
    i_start = 1'b1; i_len = 16'(len); i_passes = 8'(passes);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] base, input int n);
    int cnt = 0;
    int guard = 0;
    i_in_vld = (n > 0); i_in_data = base;
    while (cnt < n && guard < 5000) begin
      if (o_in_rdy) cnt++;
      @(negedge clk);
      guard++;
      i_in_data = base + 16'(cnt);
      i_in_vld  = (cnt < n);
    end
    i_in_vld = 1'b0;
    check("feed_count", 64'(cnt), 64'(n));
  endtask

  task automatic wait_done(input int limit);
    logic got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge clk);
      if (o_done) begin
        got = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_seen", 64'(got), 64'(1));
    check("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'(1));
    @(negedge clk);
    check("done_one_cycle", 64'(o_done), 64'(0));
    check("idle_after_done", 64'(o_busy), 64'(0));
  endtask

  task automatic job_counts(input int push, input int pop, input int mark, input int rrst,
                            input int flush, input int outs, input int lasts);
    check("push_count", 64'(n_push - b_push), 64'(push));
    check("pop_count", 64'(n_pop - b_pop), 64'(pop));
    check("mark_count", 64'(n_mark - b_mark), 64'(mark));
    check("read_rst_count", 64'(n_rrst - b_rrst), 64'(rrst));
    check("flush_count", 64'(n_flush - b_flush), 64'(flush));
    check("out_count", 64'(n_out - b_out), 64'(outs));
    check("last_count", 64'(n_last - b_last), 64'(lasts));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_passes = '0; i_in_vld = 1'b0; i_in_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out, 64'(0));
    rst_n = 1'b1;

    // Upstream valid outside FILL is not accepted.
    i_in_vld = 1'b1; i_in_data = 16'h0055;
    @(negedge clk);
    check("idle_in_rdy", 64'(o_in_rdy), 64'(0));
    check("idle_busy", 64'(o_busy), 64'(0));
    i_in_vld = 1'b0;

    // Single pass.
    snap(); expect_job(16'h00A0, 4, 1);
    start_job(4, 1);
    check("start_latency_rdy", 64'(o_in_rdy), 64'(1));
    check("busy_after_start", 64'(o_busy), 64'(1));
    feed(16'h00A0, 4);
    wait_done(200);
    check("first_vld_latency", 64'(first_vld - first_pop), 64'(2));
    job_counts(4, 4, 1, 0, 1, 4, 1);

    // Three passes.
    snap(); expect_job(16'h0010, 3, 3);
    start_job(3, 3);
    feed(16'h0010, 3);
    wait_done(300);
    job_counts(3, 9, 1, 2, 1, 9, 3);

    // Two passes with downstream backpressure.
    rdy_mode = 1;
    snap(); expect_job(16'h0020, 5, 2);
    start_job(5, 2);
    feed(16'h0020, 5);
    wait_done(400);
    rdy_mode = 0;
    job_counts(5, 10, 1, 1, 1, 10, 2);
    check("stalls_seen", 64'((n_stall - b_stall) > 0), 64'(1));
`ifdef SAMPLE_REPLAY_STATS_EN
    check("stall_cycles", 64'(o_stall_cycles), 64'(n_stall - b_stall));
`else
    check("stall_tied_zero", 64'(o_stall_cycles), 64'(0));
`endif

    // Zero length: straight to flush.
    snap();
    start_job(0, 3);
    check("zero_len_done", 64'(o_done), 64'(1));
    check("zero_len_flush", 64'(fifo_flush), 64'(1));
    @(negedge clk);
    check("zero_len_done_pulse", 64'(o_done), 64'(0));
    check("zero_len_idle", 64'(o_busy), 64'(0));
    job_counts(0, 0, 0, 0, 1, 0, 0);

    // Zero passes.
    snap();
    start_job(2, 0);
    check("zero_pass_done", 64'(o_done), 64'(1));
    @(negedge clk);
    job_counts(0, 0, 0, 0, 1, 0, 0);

    // Oversized length clamps to capacity.
    snap(); expect_job(16'h0300, 1000, 1);
    start_job(2000, 1);
    feed(16'h0300, 1000);
    check("clamp_rdy_low", 64'(o_in_rdy), 64'(0));
    wait_done(5000);
    job_counts(1000, 1000, 1, 0, 1, 1000, 1);

    // Reset while DRAIN is stalled.
    rdy_mode = 2;
    start_job(4, 2);
    feed(16'h0040, 4);
    for (int k = 0; k < 50 && !o_out_vld; k++) @(negedge clk);
    check("vld_before_reset", 64'(o_out_vld), 64'(1));
    stab_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midjob_reset_outputs", all_out, 64'(0));
    rst_n = 1'b1; rdy_mode = 0;
    @(negedge clk);
    stab_en = 1'b1;

    // Normal job after reset.
    snap(); expect_job(16'h0050, 3, 1);
    start_job(3, 1);
    feed(16'h0050, 3);
    wait_done(200);
    job_counts(3, 3, 1, 0, 1, 3, 1);

    // Start while busy is ignored.
    snap(); expect_job(16'h0060, 3, 1);
    start_job(3, 1);
    i_start = 1'b1; i_len = 16'd7; i_passes = 8'd5;
    @(negedge clk);
    i_start = 1'b0;
    feed(16'h0060, 3);
    check("rdy_after_len", 64'(o_in_rdy), 64'(0));
    wait_done(200);
    job_counts(3, 3, 1, 0, 1, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
